weight_fifo_loader: RTL and testbench
=====================================

// Module: weight_fifo_loader
// PURPOSE
//   Upstream feeder for the systolic-array weight FIFO. On a start command it reads
//   num_rows weight rows (one FIFO_WIDTH word per row) from weight memory and pushes
//   each row into the FIFO by driving its data input and per-column enables. Rows are
//   pushed last-address-first, so row base_addr ends up at the FIFO output stage.
// PARAMETERS
//   DATA_WIDTH   8   bits per weight; equals the FIFO element width
//   FIFO_INPUTS  4   columns; FIFO_WIDTH = DATA_WIDTH*FIFO_INPUTS
//   FIFO_DEPTH   4   FIFO stages; maximum rows per load
//   ADDR_WIDTH   10  weight-memory word-address width
// PORTS
//   clock        in   1                 rising-edge clock
//   reset        in   1                 asynchronous, active-low reset
//   start        in   1                 1-cycle load request; sampled only in IDLE
//   base_addr    in   ADDR_WIDTH        address of row 0
//   num_rows     in   $clog2(FIFO_DEPTH+1)  rows to load; clamped to FIFO_DEPTH
//   col_mask     in   FIFO_INPUTS       columns to update; bit i drives fifo_en[i]
//   hold         in   1                 stall: no new read is issued while high
//   mem_rd_en    out  1                 read strobe; data returns exactly 1 cycle later
//   mem_addr     out  ADDR_WIDTH        read address
//   mem_rd_data  in   FIFO_WIDTH        read data, MSB = leftmost column
//   fifo_en      out  FIFO_INPUTS       per-column shift enable to the FIFO
//   fifo_weight  out  FIFO_WIDTH        row pushed into the FIFO
//   busy         out  1                 high from start acceptance until done
//   done         out  1                 1-cycle pulse when the last push has completed
// BEHAVIOUR
//   - Reset (reset low, async): all outputs 0; FSM = IDLE; counters 0.
//   - FSM: IDLE -> ISSUE on start. ISSUE -> DRAIN after the last read. DRAIN -> PAD
//     when ZERO_PAD_EN is defined and rows < FIFO_DEPTH; otherwise DRAIN -> DONE.
//     PAD -> DONE. DONE -> IDLE (done=1 for that one cycle).
//   - start, base_addr, num_rows and col_mask are latched on acceptance.
//     start while busy is ignored.
//   - ISSUE: one read per cycle while hold=0. mem_addr = base+N-1, then counts down to base.
//     hold=1: mem_rd_en=0 and the address is held. A read already in flight still pushes.
//   - Push: the cycle after mem_rd_en=1, fifo_weight=mem_rd_data and fifo_en=col_mask.
//     All other cycles: fifo_en=0 and fifo_weight holds its last value.
//   - Timing, no hold, start accepted at edge 0:
//       mem_rd_en high cycles 1..N; fifo_en high cycles 2..N+1; done at cycle N+2.
//   - num_rows=0: no reads and no pushes; done one cycle after acceptance.
//   - num_rows>FIFO_DEPTH: treated as FIFO_DEPTH.
//   - Address arithmetic is modulo 2^ADDR_WIDTH, so base+N-1 may wrap.
//   - Reset mid-load: aborts immediately. A partial FIFO load is the owner's problem.
// CONFIGURATION
//   Macro WEIGHT_LOADER_ZERO_PAD_EN:
//   - Defined: after the N real rows, PAD pushes FIFO_DEPTH-N rows of zeros, one per
//     cycle, with fifo_en=col_mask. This fully flushes stale weights; done follows the
//     last pad push. hold does not stall PAD.
//   - Undefined: the PAD state does not exist; only N pushes occur.
// STRUCTURE
//   - Shared package weight_loader_pkg: FSM state encoding (IDLE/ISSUE/DRAIN/PAD/DONE),
//     row-count width localparam, and FIFO_WIDTH derivation.
//   - One sub-module, weight_row_counter: a loadable down-counter with terminal flag,
//     instantiated twice (read-issue count and push count).
// TESTING
//   1. DEPTH=4, base=0x010, N=4, mask=4'hF, no hold -> reads 0x013..0x010 in cycles 1-4;
//      fifo_en=F in cycles 2-5; done in cycle 6; FIFO output = word@0x010.
//   2. N=2, mask=4'b0101 -> 2 reads, fifo_en=0101 twice; masked columns unchanged.
//      With ZERO_PAD_EN: 2 extra zero pushes and done at cycle 6; without: done at cycle 4.
//   3. N=3 with hold=1 for cycles 2-3 -> the in-flight row still pushes in cycle 2;
//      reads resume in cycle 4; exactly 3 pushes in total, in order.
//   4. N=0 -> no mem_rd_en, no fifo_en; busy for 1 cycle, then a done pulse.
//      A second start while busy is ignored.
//   5. base=0x3FE, N=4 -> addresses 0x001,0x000,0x3FF,0x3FE (wrap).
//      N=7 is clamped to 4 reads.
//   6. Assert reset low in cycle 3 of a load -> all outputs 0 asynchronously; IDLE.
//      A new start is accepted after release.

Source files
------------

// File: rtl/weight_loader_pkg.sv
// Shared types and width helpers for the weight FIFO loader.
// The PAD state exists only when WEIGHT_LOADER_ZERO_PAD_EN is defined.
package weight_loader_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_FIFO_INPUTS = 4;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ADDR_WIDTH  = 10;

`ifdef WEIGHT_LOADER_ZERO_PAD_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd4
  } state_e;
`endif

  function automatic int fifo_width(input int data_width, input int fifo_inputs);
    return data_width * fifo_inputs;
  endfunction

  // Wide enough to hold every count from 0 to depth inclusive.
  function automatic int row_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_ROW_CNT_W = row_cnt_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/weight_fifo_loader_row_counter.sv
// Loadable down-counter with a terminal flag raised when one step remains.
module weight_row_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d;

  // Load wins over decrement so a reload can coincide with a final step.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == W'(1));

endmodule

// File: rtl/weight_fifo_loader.sv
// Reads up to FIFO_DEPTH weight rows last-address-first and pushes them into the
// systolic weight FIFO. Optional zero padding: WEIGHT_LOADER_ZERO_PAD_EN.
module weight_fifo_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_INPUTS = DEF_FIFO_INPUTS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           start_i,
  input  logic [ADDR_WIDTH-1:0]                          base_addr_i,
  input  logic [row_cnt_width(FIFO_DEPTH)-1:0]           num_rows_i,
  input  logic [FIFO_INPUTS-1:0]                         col_mask_i,
  input  logic                                           hold_i,
  output logic                                           mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]                          mem_addr_o,
  input  logic [fifo_width(DATA_WIDTH, FIFO_INPUTS)-1:0] mem_rd_data_i,
  output logic [FIFO_INPUTS-1:0]                         fifo_en_o,
  output logic [fifo_width(DATA_WIDTH, FIFO_INPUTS)-1:0] fifo_weight_o,
  output logic                                           busy_o,
  output logic                                           done_o
);

  localparam int FW = fifo_width(DATA_WIDTH, FIFO_INPUTS);
  localparam int CW = row_cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_e                 state_q, state_d;
  logic [FIFO_INPUTS-1:0] mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   push_q;
  logic [FW-1:0]          weight_q;

  logic                   accept;
  logic                   rd_en;
  logic                   rd_last;
  logic                   push_last;
  logic                   pad_push;
  logic                   push_load;
  logic [CW-1:0]          push_load_val;
  logic [CW-1:0]          rows_clamped;

  assign rows_clamped = (num_rows_i > DEPTH_C) ? DEPTH_C : num_rows_i;
  assign accept       = (state_q == ST_IDLE) && start_i;
  assign rd_en        = (state_q == ST_ISSUE) && !hold_i;

  // Reads walk from the last row down to base so row 0 is pushed last.
  always_comb begin
    addr_d = addr_q;
    mask_d = mask_q;
    if (accept) begin
      addr_d = base_addr_i + ADDR_WIDTH'(rows_clamped) - ADDR_WIDTH'(1);
      mask_d = col_mask_i;
    end else if (rd_en) begin
      addr_d = addr_q - ADDR_WIDTH'(1);
    end
  end

  weight_row_counter #(.W(CW)) u_rd_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_val_i (rows_clamped),
    .dec_i      (rd_en),
    .last_o     (rd_last)
  );

  weight_row_counter #(.W(CW)) u_push_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (push_load),
    .load_val_i (push_load_val),
    .dec_i      (push_q | pad_push),
    .last_o     (push_last)
  );

`ifdef WEIGHT_LOADER_ZERO_PAD_EN
  logic [CW-1:0] rows_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rows_q <= '0;
    end else if (accept) begin
      rows_q <= rows_clamped;
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    pad_push      = 1'b0;
    push_load     = accept;
    push_load_val = rows_clamped;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (rows_clamped == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rd_en && rd_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final in-flight row lands here; the push counter confirms it.
        if (push_q && push_last) begin
`ifdef WEIGHT_LOADER_ZERO_PAD_EN
          if (rows_q != DEPTH_C) begin
            state_d       = ST_PAD;
            push_load     = 1'b1;
            push_load_val = DEPTH_C - rows_q;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef WEIGHT_LOADER_ZERO_PAD_EN
      ST_PAD: begin
        pad_push = 1'b1;
        if (push_last) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      addr_q   <= '0;
      push_q   <= 1'b0;
      weight_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      push_q   <= rd_en;
      weight_q <= fifo_weight_o;
    end
  end

  // Read data arrives one cycle after the strobe and is forwarded straight through.
  always_comb begin
    fifo_weight_o = weight_q;
    if (push_q) begin
      fifo_weight_o = mem_rd_data_i;
    end else if (pad_push) begin
      fifo_weight_o = '0;
    end
  end

  assign fifo_en_o   = (push_q || pad_push) ? mask_q : '0;
  assign mem_rd_en_o = rd_en;
  assign mem_addr_o  = addr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Directed bench for weight_fifo_loader with a 1-cycle-latency memory model.
module tb_weight_fifo_loader;

`ifdef WEIGHT_LOADER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic [2:0]  num_rows_i;
  logic [3:0]  col_mask_i;
  logic        hold_i;
  logic        mem_rd_en_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_rd_data_i;
  logic [3:0]  fifo_en_o;
  logic [31:0] fifo_weight_o;
  logic        busy_o;
  logic        done_o;

  int tests;
  int fails;

  logic [31:0] mem [0:1023];
  logic [16:0] obs_v    [0:15];
  logic [9:0]  obs_addr [0:15];
  logic [31:0] obs_w    [0:15];

  weight_fifo_loader dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_rows_i    (num_rows_i),
    .col_mask_i    (col_mask_i),
    .hold_i        (hold_i),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .fifo_en_o     (fifo_en_o),
    .fifo_weight_o (fifo_weight_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'hC0DE_0000 | 32'(a);
  end

  always @(posedge clk_i) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem[mem_addr_o];
  end

  // Start accepted at edge 0; obs[k] is sampled mid-cycle k (after edge k-1).
  task automatic run_load(input logic [9:0] base, input logic [2:0] n, input logic [3:0] mask,
                          input int ncyc, input int hold_lo, input int hold_hi, input int restart_k);
    @(negedge clk_i);
    base_addr_i = base;
    num_rows_i  = n;
    col_mask_i  = mask;
    start_i     = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      hold_i = (k >= hold_lo) && (k <= hold_hi);
      if (k == restart_k) begin
        start_i     = 1'b1;
        base_addr_i = 10'h200;
        num_rows_i  = 3'd1;
        col_mask_i  = 4'h8;
      end else begin
        start_i = 1'b0;
      end
      #3;
      obs_v[k]    = {mem_rd_en_o, (mem_rd_en_o ? mem_addr_o : 10'h000), fifo_en_o, done_o, busy_o};
      obs_addr[k] = mem_addr_o;
      obs_w[k]    = fifo_weight_o;
      @(posedge clk_i);
      #1;
    end
    start_i = 1'b0;
    hold_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 1'b0; hold_i = 1'b0; base_addr_i = '0; num_rows_i = '0; col_mask_i = '0;
    @(posedge clk_i);
    #1;
    tests++;
    if ({mem_rd_en_o, mem_addr_o, fifo_en_o, fifo_weight_o, busy_o, done_o} !== 48'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h required 0",
               {mem_rd_en_o, mem_addr_o, fifo_en_o, fifo_weight_o, busy_o, done_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    $display("[TB] test_reset done");
  endtask

  // Full load, plus a second start in cycle 2 that must be ignored.
  task automatic test_full_load();
    logic [16:0] exp_v;
    logic        e_rd;
    logic [3:0]  e_en;
    run_load(10'h010, 3'd4, 4'hF, 8, 0, 0, 2);
    for (int k = 1; k <= 8; k++) begin
      e_rd  = (k <= 4);
      e_en  = (k >= 2 && k <= 5) ? 4'hF : 4'h0;
      exp_v = {e_rd, (e_rd ? 10'(16 + 4 - k) : 10'h000), e_en, (k == 6), (k <= 6)};
      tests++;
      if (obs_v[k] !== exp_v) begin
        fails++;
        $display("FAIL full_ctrl cycle %0d got %h required %h", k, obs_v[k], exp_v);
      end
      if (e_en != 4'h0) begin
        tests++;
        if (obs_w[k] !== (32'hC0DE_0000 | 32'(16 + 5 - k))) begin
          fails++;
          $display("FAIL full_weight cycle %0d got %h required %h", k, obs_w[k], 32'hC0DE_0000 | 32'(16 + 5 - k));
        end
      end
    end
    tests++;
    if (obs_w[8] !== 32'hC0DE_0010) begin
      fails++;
      $display("FAIL full_final_row got %h required %h", obs_w[8], 32'hC0DE_0010);
    end
    $display("[TB] test_full_load done");
  endtask

  task automatic test_partial_mask();
    logic [16:0] exp_v;
    logic        e_rd;
    logic [3:0]  e_en;
    int          done_k;
    logic [31:0] e_w;
    done_k = PAD ? 6 : 4;
    run_load(10'h020, 3'd2, 4'b0101, 7, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      e_rd  = (k <= 2);
      e_en  = ((k >= 2 && k <= 3) || (PAD && k >= 4 && k <= 5)) ? 4'b0101 : 4'h0;
      exp_v = {e_rd, (e_rd ? 10'(32 + 2 - k) : 10'h000), e_en, (k == done_k), (k <= done_k)};
      tests++;
      if (obs_v[k] !== exp_v) begin
        fails++;
        $display("FAIL partial_ctrl cycle %0d got %h required %h", k, obs_v[k], exp_v);
      end
      if (e_en != 4'h0) begin
        e_w = (k <= 3) ? (32'hC0DE_0000 | 32'(32 + 3 - k)) : 32'h0;
        tests++;
        if (obs_w[k] !== e_w) begin
          fails++;
          $display("FAIL partial_weight cycle %0d got %h required %h", k, obs_w[k], e_w);
        end
      end
    end
    $display("[TB] test_partial_mask done");
  endtask

  task automatic test_hold();
    logic [16:0] exp_v;
    logic        e_rd;
    logic [9:0]  e_a;
    logic [3:0]  e_en;
    logic [31:0] e_w;
    int          done_k;
    done_k = PAD ? 8 : 7;
    run_load(10'h040, 3'd3, 4'hF, 9, 2, 3, 0);
    for (int k = 1; k <= 9; k++) begin
      e_rd  = (k == 1 || k == 4 || k == 5);
      e_a   = (k == 1) ? 10'h042 : (k == 4) ? 10'h041 : (k == 5) ? 10'h040 : 10'h000;
      e_en  = (k == 2 || k == 5 || k == 6 || (PAD && k == 7)) ? 4'hF : 4'h0;
      exp_v = {e_rd, e_a, e_en, (k == done_k), (k <= done_k)};
      tests++;
      if (obs_v[k] !== exp_v) begin
        fails++;
        $display("FAIL hold_ctrl cycle %0d got %h required %h", k, obs_v[k], exp_v);
      end
      if (e_en != 4'h0) begin
        e_w = (k == 2) ? 32'hC0DE_0042 : (k == 5) ? 32'hC0DE_0041 : (k == 6) ? 32'hC0DE_0040 : 32'h0;
        tests++;
        if (obs_w[k] !== e_w) begin
          fails++;
          $display("FAIL hold_weight cycle %0d got %h required %h", k, obs_w[k], e_w);
        end
      end
    end
    for (int k = 2; k <= 3; k++) begin
      tests++;
      if (obs_addr[k] !== 10'h041) begin
        fails++;
        $display("FAIL hold_addr_held cycle %0d got %h required 041", k, obs_addr[k]);
      end
    end
    $display("[TB] test_hold done");
  endtask

  // Zero rows: done right after acceptance; a start during that cycle is ignored.
  task automatic test_zero_rows();
    logic [16:0] exp_v;
    run_load(10'h100, 3'd0, 4'hF, 5, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      exp_v = {1'b0, 10'h000, 4'h0, (k == 1), (k == 1)};
      tests++;
      if (obs_v[k] !== exp_v) begin
        fails++;
        $display("FAIL zero_rows cycle %0d got %h required %h", k, obs_v[k], exp_v);
      end
    end
    $display("[TB] test_zero_rows done");
  endtask

  task automatic test_wrap_clamp();
    logic [16:0] exp_v;
    logic        e_rd;
    logic [3:0]  e_en;
    logic [9:0]  e_a;
    run_load(10'h3FE, 3'd4, 4'hF, 7, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      e_rd  = (k <= 4);
      e_a   = 10'(32'h3FE + 4 - k);
      e_en  = (k >= 2 && k <= 5) ? 4'hF : 4'h0;
      exp_v = {e_rd, (e_rd ? e_a : 10'h000), e_en, (k == 6), (k <= 6)};
      tests++;
      if (obs_v[k] !== exp_v) begin
        fails++;
        $display("FAIL wrap_ctrl cycle %0d got %h required %h", k, obs_v[k], exp_v);
      end
    end
    tests++;
    if (obs_w[3] !== 32'hC0DE_0000) begin
      fails++;
      $display("FAIL wrap_weight got %h required %h", obs_w[3], 32'hC0DE_0000);
    end
    run_load(10'h080, 3'd7, 4'hF, 7, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      e_rd  = (k <= 4);
      e_en  = (k >= 2 && k <= 5) ? 4'hF : 4'h0;
      exp_v = {e_rd, (e_rd ? 10'(128 + 4 - k) : 10'h000), e_en, (k == 6), (k <= 6)};
      tests++;
      if (obs_v[k] !== exp_v) begin
        fails++;
        $display("FAIL clamp_ctrl cycle %0d got %h required %h", k, obs_v[k], exp_v);
      end
    end
    $display("[TB] test_wrap_clamp done");
  endtask

  task automatic test_reset_mid_load();
    logic [16:0] exp_v;
    logic [3:0]  e_en;
    int          done_k;
    @(negedge clk_i);
    base_addr_i = 10'h050; num_rows_i = 3'd4; col_mask_i = 4'hF; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    tests++;
    if ({mem_rd_en_o, mem_addr_o} !== {1'b1, 10'h051}) begin
      fails++;
      $display("FAIL midload_read got %h required %h", {mem_rd_en_o, mem_addr_o}, {1'b1, 10'h051});
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({mem_rd_en_o, mem_addr_o, fifo_en_o, fifo_weight_o, busy_o, done_o} !== 48'h0) begin
      fails++;
      $display("FAIL async_reset got %h required 0",
               {mem_rd_en_o, mem_addr_o, fifo_en_o, fifo_weight_o, busy_o, done_o});
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #2;
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle got busy=%b required 0", busy_o);
    end
    done_k = PAD ? 6 : 3;
    run_load(10'h060, 3'd1, 4'h3, 7, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      e_en  = (k == 2 || (PAD && k >= 3 && k <= 5)) ? 4'h3 : 4'h0;
      exp_v = {(k == 1), ((k == 1) ? 10'h060 : 10'h000), e_en, (k == done_k), (k <= done_k)};
      tests++;
      if (obs_v[k] !== exp_v) begin
        fails++;
        $display("FAIL restart_ctrl cycle %0d got %h required %h", k, obs_v[k], exp_v);
      end
    end
    tests++;
    if (obs_w[2] !== 32'hC0DE_0060) begin
      fails++;
      $display("FAIL restart_weight got %h required %h", obs_w[2], 32'hC0DE_0060);
    end
    $display("[TB] test_reset_mid_load done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_full_load();
    test_partial_mask();
    test_hold();
    test_zero_rows();
    test_wrap_clamp();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
